aurora_hls_status_monitor: RTL and testbench
============================================

AURORA_HLS_STATUS_MONITOR -- requirements
Module: aurora_hls_status_monitor

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 2: number of monitored FIFO almost-full flags (>=1).
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of every event counter (2..64).
REQ-003 SHALL have parameter STATUS_WIDTH, default 13: width of the Aurora core status word.
REQ-004 SHALL have parameter STATUS_OK, default 13'h11ff: status value meaning "core healthy".
REQ-005 SHALL have parameter UP_HOLD, default 16: consecutive OK cycles needed to declare link up (>=1).
REQ-006 SHALL have parameter SATURATE, default 1: 1 = counters stick at all-ones, 0 = counters wrap.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port aurora_status  input  STATUS_WIDTH  core status word, sampled every cycle.
REQ-010 SHALL have port fifo_almost_full  input  NUM_FIFOS  per-FIFO almost-full level flags.
REQ-011 SHALL have port clear  input  1  synchronous counter clear, level-sensitive, one cycle per clear.
REQ-012 SHALL have port core_status_not_ok_count  output  CNT_WIDTH  cycles with status != STATUS_OK.
REQ-013 SHALL have port fifo_overflow_count  output  NUM_FIFOS*CNT_WIDTH  per-FIFO rising-edge counts, FIFO i in bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-014 SHALL have port link_drop_count  output  CNT_WIDTH  number of UP->DOWN transitions.
REQ-015 SHALL have port last_bad_status  output  STATUS_WIDTH  most recent non-OK status value.
REQ-016 SHALL have port link_state  output  2  FSM state: 0 DOWN, 1 QUALIFY, 2 UP (3 unused).
REQ-017 SHALL have port link_up  output  1  high exactly when link_state == UP.

Function
REQ-018 All outputs SHALL be registered; each input sample affects outputs on the next rising edge (latency 1).
REQ-019 core_status_not_ok_count SHALL increment by 1 for every non-reset cycle where aurora_status != STATUS_OK.
REQ-020 last_bad_status SHALL load aurora_status on every non-reset cycle where aurora_status != STATUS_OK; otherwise it holds.
REQ-021 Each FIFO i SHALL own an armed flag; a count occurs when fifo_almost_full[i]=1 and flag=0, which then sets the flag; the flag clears when fifo_almost_full[i]=0.
REQ-022 fifo_overflow_count[i] SHALL increment once per count event per REQ-021, i.e. once per rising edge, never per cycle held high.
REQ-023 Armed flags SHALL be fully independent per channel; simultaneous edges on several FIFOs SHALL each count in the same cycle.
REQ-024 FSM DOWN: status OK -> UP if UP_HOLD==1, else QUALIFY with hold counter = 1; status not OK -> stay DOWN.
REQ-025 FSM QUALIFY: status not OK -> DOWN, hold = 0; status OK -> hold+1, and when hold+1 == UP_HOLD -> UP.
REQ-026 FSM UP: status not OK -> DOWN and link_drop_count +1; status OK -> stay UP.
REQ-027 Hold counter width SHALL be clog2(UP_HOLD+1); it SHALL never wrap.
REQ-028 SATURATE=1: a counter at all-ones SHALL hold on further events; SATURATE=0: all-ones + 1 SHALL wrap to 0.
REQ-029 clear=1 SHALL zero all three counter outputs and last_bad_status; events in that same cycle are discarded, with clear taking priority.
REQ-030 clear SHALL NOT affect the FSM, hold counter or armed flags, and those SHALL keep updating during clear.
REQ-031 An X-free design is required; the unused state encoding 3 SHALL return to DOWN on the next edge.

Reset
REQ-032 rst SHALL have priority over clear and all events.
REQ-033 On rst: all counters 0, last_bad_status 0, link_state DOWN, link_up 0, hold 0.
REQ-034 On rst: each armed flag SHALL load the current fifo_almost_full[i], so a FIFO already full at reset does not count.
REQ-035 Reset asserted mid-operation for one cycle SHALL produce the REQ-033 state on the following edge, regardless of prior state.

Verification (NUM_FIFOS=2, CNT_WIDTH=32, UP_HOLD=4 unless stated)
REQ-036 Reset with fifo_almost_full=2'b01 held 10 cycles, then 0 for 1 cycle, then 1 -> count[0] = 0 before the drop and 1 after, count[1] = 0.
REQ-037 Status 0x11ff for 3 cycles then 0x0abc for 1 cycle -> link_up never high, not_ok_count=1, last_bad_status=0x0abc, link_drop_count=0.
REQ-038 Status 0x11ff for 4 cycles -> link_up high after the 4th edge; then 0x1000 for 2 cycles -> link_drop_count=1, not_ok_count=2, last_bad_status=0x1000.
REQ-039 CNT_WIDTH=4, status bad for 20 cycles -> SATURATE=1 gives 15 (held); SATURATE=0 gives 4.
REQ-040 clear coincident with a rising edge on fifo_almost_full[1], which is then held high 5 cycles -> count[1] = 0 and stays 0, since the flag is armed.
REQ-041 With counters nonzero and link UP, a one-cycle rst -> all outputs per REQ-033 on the next edge; 4 further OK cycles -> link_up returns.

Source files
------------

// File: rtl/aurora_hls_status_monitor.sv
// -----------------------------------------------------------------------------
// aurora_hls_status_monitor
//
// Watches an Aurora core status word and a set of FIFO almost-full flags.
// It keeps event counters, remembers the last unhealthy status value and runs
// a small link-qualification state machine (DOWN -> QUALIFY -> UP).
//
// Every output is registered, so an input sample shows up one edge later.
//
// Ports
//   clk                      : sole clock, rising edge
//   rst                      : synchronous active-high reset (highest priority)
//   aurora_status            : core status word, sampled every cycle
//   fifo_almost_full         : per-FIFO almost-full level flags
//   clear                    : synchronous clear of counters and last_bad_status
//   core_status_not_ok_count : cycles where status != STATUS_OK
//   fifo_overflow_count      : per-FIFO rising-edge counts, FIFO i in [i*CNT_WIDTH +: CNT_WIDTH]
//   link_drop_count          : number of UP -> DOWN transitions
//   last_bad_status          : most recent non-OK status value
//   link_state               : 0 DOWN, 1 QUALIFY, 2 UP
//   link_up                  : high exactly when link_state == UP
// -----------------------------------------------------------------------------
module aurora_hls_status_monitor #(
  parameter int                      NUM_FIFOS    = 2,
  parameter int                      CNT_WIDTH    = 32,
  parameter int                      STATUS_WIDTH = 13,
  parameter logic [STATUS_WIDTH-1:0] STATUS_OK    = 13'h11ff,
  parameter int                      UP_HOLD      = 16,
  parameter bit                      SATURATE     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STATUS_WIDTH-1:0]        aurora_status,
  input  logic [NUM_FIFOS-1:0]           fifo_almost_full,
  input  logic                           clear,
  output logic [CNT_WIDTH-1:0]           core_status_not_ok_count,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] fifo_overflow_count,
  output logic [CNT_WIDTH-1:0]           link_drop_count,
  output logic [STATUS_WIDTH-1:0]        last_bad_status,
  output logic [1:0]                     link_state,
  output logic                           link_up
);

  // Wide enough to hold UP_HOLD itself, so hold + 1 never wraps.
  localparam int HOLD_W = $clog2(UP_HOLD + 1);

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_UP      = 2'd2
  } link_state_t;

  // Counter step: either stick at all-ones or wrap, depending on SATURATE.
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] value);
    if (SATURATE && (&value)) begin
      return value;
    end
    return value + CNT_WIDTH'(1);
  endfunction

  logic status_ok;
  assign status_ok = (aurora_status == STATUS_OK);

  // ---------------------------------------------------------------------------
  // Link qualification FSM
  // ---------------------------------------------------------------------------
  link_state_t       state_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [HOLD_W-1:0] hold_next;
  logic              link_up_reg;
  logic              drop_event;

  assign hold_next  = hold_reg + HOLD_W'(1);
  // A drop is any bad status seen while UP; this is independent of clear.
  assign drop_event = (state_reg == ST_UP) && !status_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_DOWN;
      hold_reg    <= '0;
      link_up_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_DOWN: begin
          hold_reg <= '0;
          if (status_ok) begin
            if (UP_HOLD == 1) begin
              state_reg   <= ST_UP;
              link_up_reg <= 1'b1;
            end else begin
              state_reg <= ST_QUALIFY;
              hold_reg  <= HOLD_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (!status_ok) begin
            state_reg <= ST_DOWN;
            hold_reg  <= '0;
          end else if (hold_next == HOLD_W'(UP_HOLD)) begin
            state_reg   <= ST_UP;
            hold_reg    <= '0;
            link_up_reg <= 1'b1;
          end else begin
            hold_reg <= hold_next;
          end
        end
        ST_UP: begin
          hold_reg <= '0;
          if (!status_ok) begin
            state_reg   <= ST_DOWN;
            link_up_reg <= 1'b0;
          end
        end
        default: begin
          // Unused encoding: recover to DOWN on the next edge.
          state_reg   <= ST_DOWN;
          hold_reg    <= '0;
          link_up_reg <= 1'b0;
        end
      endcase
    end
  end

  assign link_state = state_reg;
  assign link_up    = link_up_reg;

  // ---------------------------------------------------------------------------
  // Status counters and last bad value
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0]    not_ok_cnt_reg;
  logic [CNT_WIDTH-1:0]    drop_cnt_reg;
  logic [STATUS_WIDTH-1:0] last_bad_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // clear discards this cycle's events as well
      not_ok_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
      last_bad_reg   <= '0;
    end else begin
      if (!status_ok) begin
        not_ok_cnt_reg <= bump(not_ok_cnt_reg);
        last_bad_reg   <= aurora_status;
      end
      if (drop_event) begin
        drop_cnt_reg <= bump(drop_cnt_reg);
      end
    end
  end

  assign core_status_not_ok_count = not_ok_cnt_reg;
  assign link_drop_count          = drop_cnt_reg;
  assign last_bad_status          = last_bad_reg;

  // ---------------------------------------------------------------------------
  // Per-FIFO rising-edge counters
  //
  // The armed flag is set by a high flag and cleared by a low one, i.e. it is
  // simply last cycle's flag value. Loading it from the live input during
  // reset keeps a FIFO that is already full at reset from counting.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
      logic                 armed_reg;
      logic [CNT_WIDTH-1:0] ovf_cnt_reg;
      logic                 edge_event;

      assign edge_event = fifo_almost_full[gi] && !armed_reg;

      always_ff @(posedge clk) begin
        armed_reg <= fifo_almost_full[gi];
        if (rst || clear) begin
          ovf_cnt_reg <= '0;
        end else if (edge_event) begin
          ovf_cnt_reg <= bump(ovf_cnt_reg);
        end
      end

      assign fifo_overflow_count[gi*CNT_WIDTH +: CNT_WIDTH] = ovf_cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_aurora_hls_status_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for aurora_hls_status_monitor.
// Main instance: NUM_FIFOS=2, CNT_WIDTH=32, UP_HOLD=4. Two 4-bit instances
// (saturating and wrapping) share the same stimulus for counter-limit checks.
// -----------------------------------------------------------------------------
module tb_aurora_hls_status_monitor;

  localparam int          UP_HOLD = 4;
  localparam logic [12:0] OK      = 13'h11ff;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [12:0] aurora_status;
  logic [1:0]  fifo_almost_full;

  logic [31:0] not_ok_cnt, drop_cnt;
  logic [63:0] ovf_cnt;
  logic [12:0] last_bad;
  logic [1:0]  state;
  logic        up;

  logic [3:0]  s_not_ok, s_drop, w_not_ok, w_drop;
  logic [7:0]  s_ovf, w_ovf;
  logic [12:0] s_last, w_last;
  logic [1:0]  s_state, w_state;
  logic        s_up, w_up;

  always #5 clk = ~clk;

  aurora_hls_status_monitor #(
    .NUM_FIFOS(2), .CNT_WIDTH(32), .STATUS_WIDTH(13), .STATUS_OK(OK),
    .UP_HOLD(UP_HOLD), .SATURATE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .aurora_status(aurora_status),
    .fifo_almost_full(fifo_almost_full), .clear(clear),
    .core_status_not_ok_count(not_ok_cnt), .fifo_overflow_count(ovf_cnt),
    .link_drop_count(drop_cnt), .last_bad_status(last_bad),
    .link_state(state), .link_up(up)
  );

  aurora_hls_status_monitor #(
    .NUM_FIFOS(2), .CNT_WIDTH(4), .STATUS_WIDTH(13), .STATUS_OK(OK),
    .UP_HOLD(UP_HOLD), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst(rst), .aurora_status(aurora_status),
    .fifo_almost_full(fifo_almost_full), .clear(clear),
    .core_status_not_ok_count(s_not_ok), .fifo_overflow_count(s_ovf),
    .link_drop_count(s_drop), .last_bad_status(s_last),
    .link_state(s_state), .link_up(s_up)
  );

  aurora_hls_status_monitor #(
    .NUM_FIFOS(2), .CNT_WIDTH(4), .STATUS_WIDTH(13), .STATUS_OK(OK),
    .UP_HOLD(UP_HOLD), .SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .aurora_status(aurora_status),
    .fifo_almost_full(fifo_almost_full), .clear(clear),
    .core_status_not_ok_count(w_not_ok), .fifo_overflow_count(w_ovf),
    .link_drop_count(w_drop), .last_bad_status(w_last),
    .link_state(w_state), .link_up(w_up)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: unbounded event tallies since the last reset/clear plus
  // the length of the current run of OK cycles. Link state follows directly
  // from that run length; counter outputs are the tallies mapped to width.
  // ---------------------------------------------------------------------------
  int unsigned m_bad, m_drop;
  int unsigned m_ovf[2];
  logic [12:0] m_last;
  int          m_run;
  logic [1:0]  m_prev;

  task automatic model_update(input logic r, input logic c, input logic [12:0] s,
                              input logic [1:0] a);
    bit ok, drop_ev;
    bit ovf_ev[2];
    if (r) begin
      m_bad = 0; m_drop = 0; m_ovf[0] = 0; m_ovf[1] = 0;
      m_last = '0; m_run = 0; m_prev = a;
      return;
    end
    ok      = (s == OK);
    drop_ev = !ok && (m_run >= UP_HOLD);
    for (int i = 0; i < 2; i++) ovf_ev[i] = a[i] && !m_prev[i];
    m_prev = a;
    if (!ok) m_run = 0;
    else if (m_run < UP_HOLD) m_run++;
    if (c) begin
      m_bad = 0; m_drop = 0; m_ovf[0] = 0; m_ovf[1] = 0; m_last = '0;
    end else begin
      if (!ok) begin m_bad++; m_last = s; end
      if (drop_ev) m_drop++;
      for (int i = 0; i < 2; i++) if (ovf_ev[i]) m_ovf[i]++;
    end
  endtask

  function automatic logic [3:0] sat4(input int unsigned n);
    return (n > 15) ? 4'hf : 4'(n);
  endfunction

  function automatic logic [3:0] wrap4(input int unsigned n);
    return 4'(n % 16);
  endfunction

  task automatic check_model();
    logic [1:0] exp_state;
    exp_state = (m_run == 0) ? 2'd0 : ((m_run >= UP_HOLD) ? 2'd2 : 2'd1);
    chk("link_state", state, exp_state);
    chk("link_up", up, exp_state == 2'd2);
    chk("not_ok_count", not_ok_cnt, m_bad);
    chk("link_drop_count", drop_cnt, m_drop);
    chk("last_bad_status", last_bad, m_last);
    chk("ovf0", ovf_cnt[31:0], m_ovf[0]);
    chk("ovf1", ovf_cnt[63:32], m_ovf[1]);
    chk("sat_not_ok", s_not_ok, sat4(m_bad));
    chk("sat_drop", s_drop, sat4(m_drop));
    chk("sat_ovf", s_ovf, {sat4(m_ovf[1]), sat4(m_ovf[0])});
    chk("wrap_not_ok", w_not_ok, wrap4(m_bad));
    chk("wrap_drop", w_drop, wrap4(m_drop));
    chk("wrap_ovf", w_ovf, {wrap4(m_ovf[1]), wrap4(m_ovf[0])});
  endtask

  // Drive on the falling edge, let the DUT capture, sample 1 ns after.
  task automatic tick(input logic r, input logic c, input logic [12:0] s, input logic [1:0] a);
    @(negedge clk);
    rst = r; clear = c; aurora_status = s; fifo_almost_full = a;
    @(posedge clk);
    model_update(r, c, s, a);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        c;
    logic [12:0] s;
    logic [1:0]  a;
    logic [1:0]  exp_state;
    logic        exp_up;
    logic [31:0] exp_bad;
    logic [31:0] exp_drop;
    logic [12:0] exp_last;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst = 1'b1; clear = 1'b0; aurora_status = OK; fifo_almost_full = 2'b00;

    // Short status sequence that never qualifies, then a full qualify and drop.
    tbl[0]  = '{1'b1, 1'b0, OK,       2'b00, 2'd0, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[1]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[2]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[3]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[4]  = '{1'b0, 1'b0, 13'h0abc, 2'b00, 2'd0, 1'b0, 32'd1, 32'd0, 13'h0abc};
    tbl[5]  = '{1'b1, 1'b0, OK,       2'b00, 2'd0, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[6]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[7]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[8]  = '{1'b0, 1'b0, OK,       2'b00, 2'd1, 1'b0, 32'd0, 32'd0, 13'h0000};
    tbl[9]  = '{1'b0, 1'b0, OK,       2'b00, 2'd2, 1'b1, 32'd0, 32'd0, 13'h0000};
    tbl[10] = '{1'b0, 1'b0, 13'h1000, 2'b00, 2'd0, 1'b0, 32'd1, 32'd1, 13'h1000};
    tbl[11] = '{1'b0, 1'b0, 13'h1000, 2'b00, 2'd0, 1'b0, 32'd2, 32'd1, 13'h1000};

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].a);
      chk($sformatf("vec%0d state", i), state, tbl[i].exp_state);
      chk($sformatf("vec%0d link_up", i), up, tbl[i].exp_up);
      chk($sformatf("vec%0d not_ok", i), not_ok_cnt, tbl[i].exp_bad);
      chk($sformatf("vec%0d drop", i), drop_cnt, tbl[i].exp_drop);
      chk($sformatf("vec%0d last_bad", i), last_bad, tbl[i].exp_last);
      $display("vec %0d: state=%0d up=%0b not_ok=%0d drop=%0d last_bad=0x%0h",
               i, state, up, not_ok_cnt, drop_cnt, last_bad);
    end

    // FIFO 0 already full through reset must not count until it re-rises.
    tick(1'b1, 1'b0, OK, 2'b01);
    repeat (10) tick(1'b0, 1'b0, OK, 2'b01);
    chk("reset_full ovf0", ovf_cnt[31:0], 32'd0);
    chk("reset_full ovf1", ovf_cnt[63:32], 32'd0);
    tick(1'b0, 1'b0, OK, 2'b00);
    chk("after_drop ovf0", ovf_cnt[31:0], 32'd0);
    tick(1'b0, 1'b0, OK, 2'b01);
    chk("rerise ovf0", ovf_cnt[31:0], 32'd1);
    chk("rerise ovf1", ovf_cnt[63:32], 32'd0);
    $display("seq reset_full: ovf0=%0d ovf1=%0d", ovf_cnt[31:0], ovf_cnt[63:32]);

    // Simultaneous edges on both FIFOs each count.
    tick(1'b0, 1'b0, OK, 2'b00);
    tick(1'b0, 1'b0, OK, 2'b11);
    chk("simul ovf0", ovf_cnt[31:0], 32'd2);
    chk("simul ovf1", ovf_cnt[63:32], 32'd1);
    $display("seq simultaneous: ovf0=%0d ovf1=%0d", ovf_cnt[31:0], ovf_cnt[63:32]);

    // clear coincident with a rising edge: edge discarded, flag still armed.
    tick(1'b0, 1'b0, OK, 2'b00);
    tick(1'b0, 1'b1, OK, 2'b10);
    chk("clear_edge ovf0", ovf_cnt[31:0], 32'd0);
    chk("clear_edge ovf1", ovf_cnt[63:32], 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, OK, 2'b10);
      chk($sformatf("clear_hold%0d ovf1", i), ovf_cnt[63:32], 32'd0);
    end
    $display("seq clear_edge: ovf1=%0d", ovf_cnt[63:32]);

    // 20 bad cycles: 4-bit saturating sticks at 15, wrapping lands on 4.
    tick(1'b1, 1'b0, OK, 2'b00);
    repeat (20) tick(1'b0, 1'b0, 13'h0000, 2'b00);
    chk("bad20 main", not_ok_cnt, 32'd20);
    chk("bad20 sat", s_not_ok, 4'd15);
    chk("bad20 wrap", w_not_ok, 4'd4);
    $display("seq bad20: main=%0d sat=%0d wrap=%0d", not_ok_cnt, s_not_ok, w_not_ok);

    // Link UP with nonzero counters, one-cycle reset, then requalify.
    repeat (4) tick(1'b0, 1'b0, OK, 2'b00);
    chk("pre_reset up", up, 1'b1);
    tick(1'b1, 1'b0, OK, 2'b00);
    chk("mid_reset up", up, 1'b0);
    chk("mid_reset state", state, 2'd0);
    chk("mid_reset not_ok", not_ok_cnt, 32'd0);
    chk("mid_reset last_bad", last_bad, 13'h0000);
    chk("mid_reset drop", drop_cnt, 32'd0);
    chk("mid_reset ovf", ovf_cnt, 64'd0);
    repeat (3) tick(1'b0, 1'b0, OK, 2'b00);
    chk("requal3 up", up, 1'b0);
    tick(1'b0, 1'b0, OK, 2'b00);
    chk("requal4 up", up, 1'b1);
    $display("seq mid_reset: requalified up=%0b", up);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [12:0] s;
      logic [1:0]  a;
      logic        c, r;
      s = ($urandom_range(0, 9) < 8) ? OK : 13'($urandom);
      a = fifo_almost_full;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 3) == 0) a[b] = ~a[b];
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 99) == 0);
      tick(r, c, s, a);
      check_model();
    end
    $display("random: %0d cycles, not_ok=%0d drop=%0d", 1500, not_ok_cnt, drop_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
